// File: rtl/xgmii_pkg.sv
// Shared constants and types for the XGMII 64b/66b transmit encoder.
package xgmii_pkg;

    // XGMII control characters
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    // 64b/66b control block type bytes
    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_S4   = 8'h33;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;

    // Sync headers
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Control code used for every lane of an error block
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Error block: type 1E followed by eight error codes
    localparam logic [63:0] ERR_BLOCK = {{8{CODE_ERROR}}, BT_IDLE};

    typedef enum logic {
        TX_C,
        TX_D
    } tx_state_t;

    typedef enum logic [3:0] {
        DATA,
        IDLE,
        S0,
        S4,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T7,
        ERR
    } blk_class_t;

    // Terminate class for a terminate character found in lane n
    function automatic blk_class_t term_class(input int n);
        case (n)
            0:       return T0;
            1:       return T1;
            2:       return T2;
            3:       return T3;
            4:       return T4;
            5:       return T5;
            6:       return T6;
            default: return T7;
        endcase
    endfunction

    // Block type byte for a terminate character found in lane n
    function automatic logic [7:0] term_type(input int n);
        case (n)
            0:       return BT_T0;
            1:       return BT_T1;
            2:       return BT_T2;
            3:       return BT_T3;
            4:       return BT_T4;
            5:       return BT_T5;
            6:       return BT_T6;
            default: return BT_T7;
        endcase
    endfunction

    function automatic logic is_term(input blk_class_t c);
        return (c inside {[T0:T7]});
    endfunction

endpackage

// File: rtl/xgmii_block_classifier.sv
// Combinational classifier: maps one 64-bit XGMII word plus its eight
// control flags onto a block class and the encoded 64-bit block payload.
module xgmii_block_classifier
    import xgmii_pkg::*;
(
    input  logic [63:0] word,
    input  logic [7:0]  ctrl,
    output blk_class_t  blk_class,
    output logic [63:0] payload
);

    logic all_idle;
    logic tail_ok;
    logic term_hit;

    // Try each legal block format in turn; anything unmatched is an error block
    always_comb begin
        blk_class = ERR;
        payload   = ERR_BLOCK;
        all_idle  = 1'b1;
        tail_ok   = 1'b1;
        term_hit  = 1'b0;

        for (int k = 0; k < 8; k++) begin
            if (word[8*k +: 8] != XGMII_IDLE && word[8*k +: 8] != XGMII_ERROR) begin
                all_idle = 1'b0;
            end
        end

        if (ctrl == 8'h00) begin
            blk_class = DATA;
            payload   = word;
        end else if (ctrl == 8'hFF && all_idle) begin
            blk_class = IDLE;
            payload   = {56'b0, BT_IDLE};
            for (int k = 0; k < 8; k++) begin
                payload[8 + 7*k +: 7] = (word[8*k +: 8] == XGMII_ERROR) ? CODE_ERROR : 7'h00;
            end
        end else if (ctrl == 8'h01 && word[7:0] == XGMII_START) begin
            blk_class = S0;
            payload   = {word[63:8], BT_S0};
        end else if (ctrl == 8'h1F && word[31:0] == {4{XGMII_IDLE}} &&
                     word[39:32] == XGMII_START) begin
            blk_class = S4;
            payload   = {word[63:40], 4'b0, 28'b0, BT_S4};
        end else begin
            for (int n = 0; n < 8; n++) begin
                tail_ok = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    if (k > n && word[8*k +: 8] != XGMII_IDLE) begin
                        tail_ok = 1'b0;
                    end
                end
                if (!term_hit && ctrl == (8'hFF << n) &&
                    word[8*n +: 8] == XGMII_TERM && tail_ok) begin
                    term_hit  = 1'b1;
                    blk_class = term_class(n);
                    payload   = {56'b0, term_type(n)};
                    for (int k = 0; k < 7; k++) begin
                        if (k < n) begin
                            payload[8*(k+1) +: 8] = word[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/xgmii_encoder.sv
// TX 64b/66b encoder: pairs 32-bit XGMII beats into 64-bit words, encodes
// each word as a data or control block, enforces C/D sequencing and streams
// the block out as two 32-bit halves with the sync header on the low half.
module xgmii_encoder
    import xgmii_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CTRL_WIDTH    = 4,
    parameter int HDR_WIDTH     = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [DATA_WIDTH-1:0]    i_xgmii_txd,
    input  logic [CTRL_WIDTH-1:0]    i_xgmii_txc,
    input  logic                     i_xgmii_valid,
    output logic [DATA_WIDTH-1:0]    o_tx_data,
    output logic                     o_tx_data_valid,
    output logic [HDR_WIDTH-1:0]     o_tx_hdr,
    output logic                     o_tx_hdr_valid,
    output logic                     o_enc_error,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    logic                    toggle;
    logic                    primed;
    logic [DATA_WIDTH-1:0]   beat0_data;
    logic [CTRL_WIDTH-1:0]   beat0_ctrl;
    logic [DATA_WIDTH-1:0]   hi_hold;
    tx_state_t               state;

    blk_class_t              blk_class;
    logic [2*DATA_WIDTH-1:0] cls_payload;
    logic [2*DATA_WIDTH-1:0] enc_payload;
    logic [HDR_WIDTH-1:0]    enc_hdr;
    logic                    blk_err;
    tx_state_t               next_state;

    xgmii_block_classifier u_classifier (
        .word      ({i_xgmii_txd, beat0_data}),
        .ctrl      ({i_xgmii_txc, beat0_ctrl}),
        .blk_class (blk_class),
        .payload   (cls_payload)
    );

    // Apply the C/D sequencing rules; illegal transitions become error blocks
    always_comb begin
        next_state  = state;
        blk_err     = 1'b0;
        enc_payload = cls_payload;
        enc_hdr     = SYNC_CTRL;

        case (state)
            TX_C: begin
                if (blk_class == S0 || blk_class == S4) begin
                    next_state = TX_D;
                end else if (blk_class != IDLE) begin
                    blk_err = 1'b1;
                end
            end
            TX_D: begin
                if (is_term(blk_class)) begin
                    next_state = TX_C;
                end else if (blk_class != DATA) begin
                    blk_err = 1'b1;
                end
            end
            default: blk_err = 1'b1;
        endcase

        if (blk_err) begin
            next_state  = TX_C;
            enc_payload = ERR_BLOCK;
        end else if (blk_class == DATA) begin
            enc_hdr = SYNC_DATA;
        end
    end

    // Beat pairing, sequencing state and registered output stream
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            toggle          <= 1'b0;
            primed          <= 1'b0;
            beat0_data      <= '0;
            beat0_ctrl      <= '0;
            hi_hold         <= '0;
            state           <= TX_C;
            o_tx_data       <= '0;
            o_tx_data_valid <= 1'b0;
            o_tx_hdr        <= '0;
            o_tx_hdr_valid  <= 1'b0;
            o_enc_error     <= 1'b0;
            o_err_count     <= '0;
        end else begin
            o_tx_data_valid <= 1'b0;
            o_tx_hdr_valid  <= 1'b0;
            o_enc_error     <= 1'b0;
            if (i_xgmii_valid) begin
                toggle <= ~toggle;
                if (!toggle) begin
                    beat0_data      <= i_xgmii_txd;
                    beat0_ctrl      <= i_xgmii_txc;
                    o_tx_data_valid <= primed;
                    if (primed) begin
                        o_tx_data <= hi_hold;
                    end
                end else begin
                    o_tx_data       <= enc_payload[DATA_WIDTH-1:0];
                    hi_hold         <= enc_payload[2*DATA_WIDTH-1:DATA_WIDTH];
                    o_tx_hdr        <= enc_hdr;
                    o_tx_hdr_valid  <= 1'b1;
                    o_tx_data_valid <= 1'b1;
                    primed          <= 1'b1;
                    state           <= next_state;
                    if (blk_err) begin
                        o_enc_error <= 1'b1;
                        if (o_err_count != '1) begin
                            o_err_count <= o_err_count + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xgmii_encoder.sv
// Directed-vector bench for the XGMII 64b/66b transmit encoder.
module tb_xgmii_encoder;

    logic        clk;
    logic        reset_n;
    logic [31:0] txd;
    logic [3:0]  txc;
    logic        valid;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic [1:0]  tx_hdr;
    logic        tx_hdr_valid;
    logic        enc_error;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

    xgmii_encoder dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_xgmii_txd     (txd),
        .i_xgmii_txc     (txc),
        .i_xgmii_valid   (valid),
        .o_tx_data       (tx_data),
        .o_tx_data_valid (tx_data_valid),
        .o_tx_hdr        (tx_hdr),
        .o_tx_hdr_valid  (tx_hdr_valid),
        .o_enc_error     (enc_error),
        .o_err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input, then sample outputs just after the edge
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] c, input logic v);
        @(negedge clk);
        txd   = d;
        txc   = c;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Low-half beat of a block: header valid, header, data, error pulse
    task automatic checkLow(input string tag, input logic [31:0] d, input logic [1:0] h, input logic err);
        checkOutput({tag, "_vld"}, 64'(tx_data_valid), 64'(1));
        checkOutput({tag, "_hvld"}, 64'(tx_hdr_valid), 64'(1));
        checkOutput({tag, "_hdr"}, 64'(tx_hdr), 64'(h));
        checkOutput({tag, "_data"}, 64'(tx_data), 64'(d));
        checkOutput({tag, "_err"}, 64'(enc_error), 64'(err));
    endtask

    // High-half beat of a block: no header, no error pulse
    task automatic checkHigh(input string tag, input logic [31:0] d);
        checkOutput({tag, "_vld"}, 64'(tx_data_valid), 64'(1));
        checkOutput({tag, "_hvld"}, 64'(tx_hdr_valid), 64'(0));
        checkOutput({tag, "_data"}, 64'(tx_data), 64'(d));
        checkOutput({tag, "_err"}, 64'(enc_error), 64'(0));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data"}, 64'(tx_data), 64'(0));
        checkOutput({tag, "_vld"}, 64'(tx_data_valid), 64'(0));
        checkOutput({tag, "_hdr"}, 64'(tx_hdr), 64'(0));
        checkOutput({tag, "_hvld"}, 64'(tx_hdr_valid), 64'(0));
        checkOutput({tag, "_err"}, 64'(enc_error), 64'(0));
        checkOutput({tag, "_cnt"}, 64'(err_count), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        txd     = '0;
        txc     = '0;
        valid   = 1'b0;
        repeat (3) applyStimulus(32'h0, 4'h0, 1'b0);
        checkResetOutputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle stream: four IDLE blocks
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h07070707, 4'hF, 1'b1);
            if (i == 0) checkOutput("idle_unprimed_vld", 64'(tx_data_valid), 64'(0));
            else        checkHigh("idle_hi", 32'h00000000);
            applyStimulus(32'h07070707, 4'hF, 1'b1);
            checkLow("idle_lo", 32'h0000001E, 2'b10, 1'b0);
        end

        // Frame: S0, two data blocks, T4
        applyStimulus(32'h555555FB, 4'h1, 1'b1);
        checkHigh("idle_last_hi", 32'h00000000);
        applyStimulus(32'hD5555555, 4'h0, 1'b1);
        checkLow("s0_lo", 32'h55555578, 2'b10, 1'b0);
        applyStimulus(32'h11223344, 4'h0, 1'b1);
        checkHigh("s0_hi", 32'hD5555555);
        applyStimulus(32'h55667788, 4'h0, 1'b1);
        checkLow("d1_lo", 32'h11223344, 2'b01, 1'b0);
        applyStimulus(32'h99AABBCC, 4'h0, 1'b1);
        checkHigh("d1_hi", 32'h55667788);
        applyStimulus(32'hDDEEFF00, 4'h0, 1'b1);
        checkLow("d2_lo", 32'h99AABBCC, 2'b01, 1'b0);
        applyStimulus(32'h04030201, 4'h0, 1'b1);
        checkHigh("d2_hi", 32'hDDEEFF00);
        applyStimulus(32'h070707FD, 4'hF, 1'b1);
        checkLow("t4_lo", 32'h030201CC, 2'b10, 1'b0);

        // S4 start, legal only because the frame returned to TX_C
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkHigh("t4_hi", 32'h00000004);
        applyStimulus(32'hAABBCCFB, 4'h1, 1'b1);
        checkLow("s4_lo", 32'h00000033, 2'b10, 1'b0);

        // T0 closes the S4 frame
        applyStimulus(32'h070707FD, 4'hF, 1'b1);
        checkHigh("s4_hi", 32'hAABBCC00);
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkLow("t0_lo", 32'h00000087, 2'b10, 1'b0);

        // Data block while in TX_C becomes an error block
        applyStimulus(32'h01020304, 4'h0, 1'b1);
        checkHigh("t0_hi", 32'h00000000);
        applyStimulus(32'h05060708, 4'h0, 1'b1);
        checkLow("seq_err_lo", 32'hC78F1E1E, 2'b10, 1'b1);
        checkOutput("seq_err_cnt", 64'(err_count), 64'(1));

        // S0 after the error is encoded normally
        applyStimulus(32'h000000FB, 4'h1, 1'b1);
        checkHigh("seq_err_hi", 32'h3C78F1E3);
        applyStimulus(32'h11111111, 4'h0, 1'b1);
        checkLow("s0b_lo", 32'h00000078, 2'b10, 1'b0);
        checkOutput("s0b_cnt", 64'(err_count), 64'(1));

        // Stall between beat0 and beat1 of a data block
        applyStimulus(32'hAABBCCDD, 4'h0, 1'b1);
        checkHigh("s0b_hi", 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'hDEADBEEF, 4'h0, 1'b0);
            checkOutput("stall_vld", 64'(tx_data_valid), 64'(0));
            checkOutput("stall_hvld", 64'(tx_hdr_valid), 64'(0));
        end
        applyStimulus(32'hEEFF0011, 4'h0, 1'b1);
        checkLow("stall_lo", 32'hAABBCCDD, 2'b01, 1'b0);

        // T7 ends the frame
        applyStimulus(32'h33221100, 4'h0, 1'b1);
        checkHigh("stall_hi", 32'hEEFF0011);
        applyStimulus(32'hFD665544, 4'h8, 1'b1);
        checkLow("t7_lo", 32'h221100FF, 2'b10, 1'b0);

        // Reset after beat0 only
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkHigh("t7_hi", 32'h66554433);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) applyStimulus(32'h07070707, 4'hF, 1'b0);
        checkResetOutputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkOutput("post_reset_unprimed_vld", 64'(tx_data_valid), 64'(0));
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkLow("post_reset_idle_lo", 32'h0000001E, 2'b10, 1'b0);
        checkOutput("post_reset_cnt", 64'(err_count), 64'(0));

        // Malformed control word classifies as an error block
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkHigh("post_reset_idle_hi", 32'h00000000);
        applyStimulus(32'h0707070A, 4'hF, 1'b1);
        checkLow("bad_ctrl_lo", 32'hC78F1E1E, 2'b10, 1'b1);
        checkOutput("bad_ctrl_cnt", 64'(err_count), 64'(1));
        applyStimulus(32'h07070707, 4'hF, 1'b1);
        checkHigh("bad_ctrl_hi", 32'h3C78F1E3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
